hm74_serial_rx: RTL

Serial receiver for Hamming(7,4)-protected nibbles: deserialises a framed, single-wire bitstream, corrects any single-bit error in each 7-bit codeword, and presents the recovered nibble with its syndrome over a valid/ready handshake. It is the receiving end of the serial Hamming link and sits between a chip input pin and the user logic consuming decoded nibbles. It uses the same codeword bit layout as the team's Hamming(7,4) encoder.

---
 rtl/hm74_pkg.sv | 14 +
 rtl/hm74_correct.sv | 29 ++
 rtl/hm74_serial_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hm74_pkg.sv
// Shared constants and FSM state type for the Hamming(7,4) serial receiver.
package hm74_pkg;
  localparam int CW_W       = 7;
  localparam int DATA_W     = 4;
  localparam int SYN_W      = 3;
  localparam int ERRCNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;
endpackage

// File: rtl/hm74_correct.sv
// Combinational Hamming(7,4) syndrome decode with single-bit correction.
module hm74_correct
  import hm74_pkg::*;
(
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic [SYN_W-1:0]  o_syndrome
);

  logic [SYN_W-1:0] w_syn;
  logic [CW_W-1:0]  w_fixed;

  // Syndrome value k names the erroneous bit r(k-1).
  always_comb begin
    w_syn[0] = i_cw[0] ^ i_cw[2] ^ i_cw[4] ^ i_cw[6];
    w_syn[1] = i_cw[1] ^ i_cw[2] ^ i_cw[5] ^ i_cw[6];
    w_syn[2] = i_cw[3] ^ i_cw[4] ^ i_cw[5] ^ i_cw[6];
    w_fixed  = i_cw;
    if (w_syn != 3'd0) begin
      w_fixed = i_cw ^ (7'd1 << (w_syn - 3'd1));
    end else begin
      w_fixed = i_cw;
    end
  end

  assign o_data     = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
  assign o_syndrome = w_syn;

endmodule

// File: rtl/hm74_serial_rx.sv
// Framed serial receiver for Hamming(7,4) nibbles with valid/ready output.
// Optional error counter enabled by defining HM74_RX_ERRCNT_EN.
module hm74_serial_rx
  import hm74_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr,
  output logic [7:0]        err_count
);

  localparam logic [7:0] CNT_FULL = 8'(CLKS_PER_BIT);
  localparam logic [7:0] CNT_HALF = 8'(CLKS_PER_BIT / 2);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_sync1;
  logic               r_rxs;
  logic [7:0]         r_cnt;
  logic [2:0]         r_bit_idx;
  logic [CW_W-1:0]    r_shift;
  logic [DATA_W-1:0]  r_data;
  logic [SYN_W-1:0]   r_syn;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_overrun;

  logic               w_tick;
  logic               w_sample_bit;
  logic               w_stop_sample;
  logic               w_stop_ok;
  logic               w_load;
  logic [DATA_W-1:0]  w_dec_data;
  logic [SYN_W-1:0]   w_dec_syn;

  hm74_correct u_correct (
    .i_cw       (r_shift),
    .o_data     (w_dec_data),
    .o_syndrome (w_dec_syn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_state <= IDLE;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_state <= w_state_nxt;
    end
  end

  // Counter reaching 1 marks the mid-bit sample point.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick        = (r_cnt <= 8'd1);
    w_sample_bit  = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs) w_state_nxt = START;
        else        w_state_nxt = IDLE;
      end
      START: begin
        if (w_tick) w_state_nxt = r_rxs ? IDLE : DATA;
        else        w_state_nxt = START;
      end
      DATA: begin
        if (w_tick) begin
          w_sample_bit = 1'b1;
          w_state_nxt  = (r_bit_idx == 3'd6) ? STOP : DATA;
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_stop_sample = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= CNT_HALF;
      r_bit_idx <= 3'd0;
      r_shift   <= '0;
    end else begin
      if (r_state == IDLE) r_cnt <= CNT_HALF;
      else if (w_tick)     r_cnt <= CNT_FULL;
      else                 r_cnt <= r_cnt - 8'd1;
      if (r_state != DATA)   r_bit_idx <= 3'd0;
      else if (w_sample_bit) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_sample_bit) r_shift <= {r_rxs, r_shift[CW_W-1:1]};
    end
  end

  assign w_stop_ok = w_stop_sample & r_rxs;
  assign w_load    = w_stop_ok & (~r_valid | ready);

  // A load in the same cycle as an accept wins, so valid stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_syn       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_sample & ~r_rxs;
      r_overrun   <= w_stop_ok & r_valid & ~ready;
      if (w_load) begin
        r_data  <= w_dec_data;
        r_syn   <= w_dec_syn;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign syndrome  = r_syn;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

`ifdef HM74_RX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (err_clr) begin
      r_err_count <= 8'd0;
    end else if (w_load && (w_dec_syn != 3'd0) && (r_err_count != 8'(ERRCNT_MAX))) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_count        = 8'd0;
`endif

endmodule
